// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/ALU-op constants, FSM state encoding and strobe bundle for the multi-cycle control unit.
// ILLEGAL_TRAP_EN adds the TRAP state and the illegal strobe.
package cpu_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  typedef enum logic [3:0] {
    FETCH, DECODE, EX_ADDR, EX_R, EX_BEQ, MEM_RD, MEM_WR, WB_LD, WB_R
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_e;
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;
endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: control unit <-> datapath/memory signals; master is the control unit.
// ILLEGAL_TRAP_EN adds illegal_instr.
interface mc_control_fsm_if #(parameter int CNT_W = 32);
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             zero;
  logic             ir_write;
  logic             pc_write;
  logic             pc_branch;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             reg_write;
  logic             mem_to_reg;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_instr;
`endif
  modport master (
    input  opcode, mem_ready, zero,
    output ir_write, pc_write, pc_branch, mem_read, mem_write, i_or_d,
           alu_op, alu_src, reg_write, mem_to_reg, instret, state_o
`ifdef ILLEGAL_TRAP_EN
           , illegal_instr
`endif
  );
  modport slave (
    output opcode, mem_ready, zero,
    input  ir_write, pc_write, pc_branch, mem_read, mem_write, i_or_d,
           alu_op, alu_src, reg_write, mem_to_reg, instret, state_o
`ifdef ILLEGAL_TRAP_EN
           , illegal_instr
`endif
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state -> Moore strobe table.
// ILLEGAL_TRAP_EN adds the illegal strobe in TRAP.
module mc_ctrl_decode
  import cpu_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);
  always_comb begin
    ctrl_o            = '0;
    ctrl_o.mem_read   = state_i == FETCH || state_i == MEM_RD;
    ctrl_o.mem_write  = state_i == MEM_WR;
    ctrl_o.i_or_d     = state_i == MEM_RD || state_i == MEM_WR;
    ctrl_o.alu_op     = state_i == EX_R ? ALUOP_R : state_i == EX_BEQ ? ALUOP_BR : ALUOP_MEM;
    ctrl_o.alu_src    = state_i == EX_ADDR;
    ctrl_o.reg_write  = state_i == WB_LD || state_i == WB_R;
    ctrl_o.mem_to_reg = state_i == WB_LD;
`ifdef ILLEGAL_TRAP_EN
    ctrl_o.illegal    = state_i == TRAP;
`endif
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle lw/sw/beq/R-type control FSM with retired-instruction counter.
// ILLEGAL_TRAP_EN traps unknown opcodes in TRAP until reset instead of retiring them as NOPs.
module mc_control_fsm
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  mc_control_fsm_if.master bus
);
`ifdef ILLEGAL_TRAP_EN
  localparam state_e ILL_NEXT = TRAP;
`else
  localparam state_e ILL_NEXT = FETCH;
`endif
  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;
  ctrl_t            ctrl;
  mc_ctrl_decode u_dec (.state_i(state_q), .ctrl_o(ctrl));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end
  // DECODE only falls back to FETCH for an unknown opcode, which retires as a NOP
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH:   state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        state_d = (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? EX_ADDR :
                  bus.opcode == OP_RTYPE  ? EX_R :
                  bus.opcode == OP_BRANCH ? EX_BEQ : ILL_NEXT;
        retire  = state_d == FETCH;
      end
      EX_ADDR: state_d = bus.opcode == OP_STORE ? MEM_WR : MEM_RD;
      EX_R:    state_d = WB_R;
      MEM_RD:  state_d = bus.mem_ready ? WB_LD : MEM_RD;
      MEM_WR: begin
        state_d = bus.mem_ready ? FETCH : MEM_WR;
        retire  = bus.mem_ready;
      end
      EX_BEQ, WB_LD, WB_R: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = state_q;
    endcase
  end
  always_comb begin
    bus.ir_write   = !rst && state_q == FETCH && bus.mem_ready;
    bus.pc_write   = !rst && state_q == FETCH && bus.mem_ready;
    bus.pc_branch  = !rst && state_q == EX_BEQ && bus.zero;
    bus.mem_read   = rst ? 1'b0 : ctrl.mem_read;
    bus.mem_write  = rst ? 1'b0 : ctrl.mem_write;
    bus.i_or_d     = rst ? 1'b0 : ctrl.i_or_d;
    bus.alu_op     = rst ? ALUOP_MEM : ctrl.alu_op;
    bus.alu_src    = rst ? 1'b0 : ctrl.alu_src;
    bus.reg_write  = rst ? 1'b0 : ctrl.reg_write;
    bus.mem_to_reg = rst ? 1'b0 : ctrl.mem_to_reg;
    bus.instret    = instret_q;
    bus.state_o    = state_q;
`ifdef ILLEGAL_TRAP_EN
    bus.illegal_instr = rst ? 1'b0 : ctrl.illegal;
`endif
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit; the producer side of the ALU control interface.
- Sequences the design's instruction set through fetch/decode/execute/memory/writeback: lw, sw, beq, R-type add/sub/and/or.
- Drives ALUOp, ALUSrc, memory strobes, register-file write and PC update.
- Counts retired instructions; waits on a single memory-ready handshake for instruction and data accesses.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- opcode  in  7  instr[6:0] from instruction register.
- mem_ready  in  1  memory accepted/completed current access this cycle.
- zero  in  1  ALU zero flag, valid in EXEC_BEQ.
- ir_write  out  1  load instruction register.
- pc_write  out  1  unconditional PC update (PC+4).
- pc_branch  out  1  load PC with branch target.
- mem_read  out  1  memory read strobe (fetch or load).
- mem_write  out  1  memory write strobe.
- i_or_d  out  1  0 = instruction address (PC), 1 = data address (ALU result register).
- alu_op  out  2  00 load/store, 01 beq, 10 R-type; matches ALU decode.
- alu_src  out  1  0 = read_data2, 1 = imm32.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback select: 1 = memory data, 0 = ALU result.
- instret  out  CNT_W  retired-instruction count.
- state_o  out  4  current state, for debug.

Behaviour:
- Encodings: lw 0000011, sw 0100011, beq 1100011, R 0110011. funct3/funct7 are not decoded here; the ALU consumes them.
- States: FETCH, DECODE, EX_ADDR, EX_R, EX_BEQ, MEM_RD, MEM_WR, WB_LD, WB_R, TRAP (TRAP only with the optional feature).
- Reset: synchronous. State = FETCH; all strobes = 0; alu_op = 00; alu_src = 0; instret = 0. rst asserted mid-access aborts immediately; no strobe is held on the next cycle.
- Outputs are Moore (decoded from state), except ir_write, pc_write, pc_branch and the state advance, which also qualify on mem_ready/zero.
- FETCH:
  - mem_read = 1, i_or_d = 0; hold until mem_ready.
  - On mem_ready: ir_write = 1, pc_write = 1 for that cycle; next state DECODE.
- DECODE: one cycle, no strobes. Next state by opcode:
  - lw/sw -> EX_ADDR.
  - R -> EX_R.
  - beq -> EX_BEQ.
  - other -> FETCH (feature off); counts as retired NOP.
- EX_ADDR: alu_op = 00, alu_src = 1. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read = 1, i_or_d = 1; wait for mem_ready -> WB_LD.
- MEM_WR: mem_write = 1, i_or_d = 1; wait for mem_ready -> FETCH, retire.
- WB_LD: reg_write = 1, mem_to_reg = 1 -> FETCH, retire.
- EX_R: alu_op = 10, alu_src = 0 -> WB_R.
- WB_R: reg_write = 1, mem_to_reg = 0 -> FETCH, retire.
- EX_BEQ: alu_op = 01, alu_src = 0; pc_branch = zero -> FETCH, retire.
- Latency: lw 5 states, sw 4, R 4, beq 3, plus one extra cycle per cycle mem_ready is low.
- instret:
  - Increments by 1 in the retiring cycle; wraps modulo 2^CNT_W with no saturation.
  - At most one increment per cycle.
  - A retire coinciding with rst is lost (reset wins).
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- mem_read and mem_write are never both 1.
- pc_write and pc_branch are never both 1.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode in DECODE -> TRAP.
  - TRAP holds all strobes 0, asserts extra output illegal_instr = 1, does not retire.
  - Exit only via rst.
- Undefined: no TRAP state, no illegal_instr port; unknown opcode is a NOP as above.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE;
  - alu_op constants ALUOP_MEM = 00, ALUOP_BR = 01, ALUOP_R = 10;
  - state enum encoding.
- Optional sub-module mc_ctrl_decode: combinational state -> strobe table; FSM and counter stay in mc_control_fsm.

Test Plan:
- rst held 3 cycles, then released with mem_ready = 1 -> state_o = FETCH, all strobes 0 during reset, instret = 0; first post-reset cycle has mem_read = 1, i_or_d = 0.
- lw (opcode 0000011), mem_ready always 1 -> sequence FETCH, DECODE, EX_ADDR(alu_op = 00, alu_src = 1), MEM_RD, WB_LD(reg_write = 1, mem_to_reg = 1); instret 0 -> 1 after 5 cycles.
- sw with mem_ready low 3 cycles in MEM_WR -> mem_write held high 4 cycles, reg_write never 1, retire on the 4th cycle.
- beq with zero = 1, then beq with zero = 0 -> pc_branch pulses once, only for the first; both retire; instret += 2.
- R-type (0110011) back-to-back x4 -> alu_op = 10 in EX_R, reg_write in WB_R; instret = 4 after 16 cycles; rst asserted during the 3rd instruction's EX_R -> FETCH next cycle, instret = 0.
- Opcode 1111111: with ILLEGAL_TRAP_EN -> TRAP, illegal_instr = 1, stuck until rst; without it -> FETCH after DECODE, instret += 1.
